vga_fill_ctrl: RTL and testbench

VGA_FILL_CTRL -- requirements
Module: vga_fill_ctrl

---
 rtl/vga_fill_ctrl.sv | 130 +++++++++++++
 tb/tb_vga_fill_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fill_ctrl.sv
// Rectangle fill engine: streams one colour into a framebuffer in raster
// order, optionally only while the display is blanked.
module vga_fill_ctrl #(
   parameter int H_MAX      = 640,
   parameter int V_MAX      = 480,
   parameter int BLANK_ONLY = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_cmd_valid,
   output logic        o_cmd_ready,
   input  logic [9:0]  i_cmd_x,
   input  logic [8:0]  i_cmd_y,
   input  logic [9:0]  i_cmd_w,
   input  logic [8:0]  i_cmd_h,
   input  logic [23:0] i_cmd_color,
   input  logic        i_blank_n,
   input  logic        i_abort,
   output logic        o_wr_en,
   output logic [9:0]  o_wr_h_addr,
   output logic [8:0]  o_wr_v_addr,
   output logic [23:0] o_wr_data,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [10:0] LP_HMAX  = 11'(H_MAX);
   localparam logic [9:0]  LP_VMAX  = 10'(V_MAX);
   localparam logic [9:0]  LP_HLAST = 10'(H_MAX - 1);
   localparam logic [8:0]  LP_VLAST = 9'(V_MAX - 1);

   state_t      r_state;
   state_t      w_next;
   logic [9:0]  r_x;
   logic [9:0]  r_h;
   logic [9:0]  r_x_end;
   logic [8:0]  r_v;
   logic [8:0]  r_y_end;
   logic [23:0] r_color;

   logic        w_accept;
   logic        w_bad;
   logic        w_gate;
   logic        w_wr;
   logic        w_last;
   logic [10:0] w_xe_sum;
   logic [9:0]  w_ye_sum;
   logic [9:0]  w_x_end;
   logic [8:0]  w_y_end;

   assign w_accept = i_cmd_valid && (r_state == S_IDLE);
   assign w_bad = (i_cmd_w == 10'd0) || (i_cmd_h == 9'd0)
               || ({1'b0, i_cmd_x} >= LP_HMAX)
               || ({1'b0, i_cmd_y} >= LP_VMAX);

   // widened sums so a rectangle running off the edge clips instead of wrapping
   assign w_xe_sum = {1'b0, i_cmd_x} + {1'b0, i_cmd_w} - 11'd1;
   assign w_ye_sum = {1'b0, i_cmd_y} + {1'b0, i_cmd_h} - 10'd1;
   assign w_x_end  = (w_xe_sum > {1'b0, LP_HLAST}) ? LP_HLAST : w_xe_sum[9:0];
   assign w_y_end  = (w_ye_sum > {1'b0, LP_VLAST}) ? LP_VLAST : w_ye_sum[8:0];

   assign w_gate = !i_abort && ((BLANK_ONLY == 0) || !i_blank_n);
   assign w_wr   = (r_state == S_FILL) && w_gate;
   assign w_last = w_wr && (r_h == r_x_end) && (r_v == r_y_end);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: if (w_accept) w_next = w_bad ? S_ERR : S_FILL;
         S_FILL: begin
            if (i_abort)     w_next = S_IDLE;
            else if (w_last) w_next = S_DONE;
         end
         S_DONE:  w_next = S_IDLE;
         S_ERR:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      o_cmd_ready = (r_state == S_IDLE);
      o_wr_en     = w_wr;
      o_busy      = (r_state == S_FILL) || (r_state == S_DONE);
      o_done      = (r_state == S_DONE);
      o_err       = (r_state == S_ERR);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_x     <= '0;
         r_h     <= '0;
         r_x_end <= '0;
         r_v     <= '0;
         r_y_end <= '0;
         r_color <= '0;
      end else if (w_accept) begin
         r_x     <= i_cmd_x;
         r_h     <= i_cmd_x;
         r_x_end <= w_x_end;
         r_v     <= i_cmd_y;
         r_y_end <= w_y_end;
         r_color <= i_cmd_color;
      end else if (w_wr) begin
         if (r_h == r_x_end) begin
            r_h <= r_x;
            r_v <= r_v + 9'd1;
         end else begin
            r_h <= r_h + 10'd1;
         end
      end
   end

   assign o_wr_h_addr = r_h;
   assign o_wr_v_addr = r_v;
   assign o_wr_data   = r_color;

endmodule

// File: tb/tb_vga_fill_ctrl.sv
// Scoreboard bench: a blank-gated instance and an ungated instance share
// stimulus; each write and done/err pulse is popped from a per-instance queue.
module tb_vga_fill_ctrl;

   typedef struct {
      int h;
      int v;
      int d;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic [9:0]  cmd_x;
   logic [8:0]  cmd_y;
   logic [9:0]  cmd_w;
   logic [8:0]  cmd_h;
   logic [23:0] cmd_c;
   logic        blank_n;
   logic        abort;

   logic        rdy1, wr1, busy1, done1, err1;
   logic [9:0]  ha1;
   logic [8:0]  va1;
   logic [23:0] d1;
   logic        rdy0, wr0, busy0, done0, err0;
   logic [9:0]  ha0;
   logic [8:0]  va0;
   logic [23:0] d0;

   wr_t q0[$];
   wr_t q1[$];
   byte ev0[$];
   byte ev1[$];

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int n_wr1  = 0;
   int last0  = -10;
   int last1  = -10;
   bit blank_rand = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   vga_fill_ctrl #(.BLANK_ONLY(1)) u1 (
      .i_clk(clk), .i_rst(rst),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(rdy1),
      .i_cmd_x(cmd_x), .i_cmd_y(cmd_y),
      .i_cmd_w(cmd_w), .i_cmd_h(cmd_h),
      .i_cmd_color(cmd_c), .i_blank_n(blank_n),
      .i_abort(abort), .o_wr_en(wr1),
      .o_wr_h_addr(ha1), .o_wr_v_addr(va1),
      .o_wr_data(d1), .o_busy(busy1),
      .o_done(done1), .o_err(err1)
   );

   vga_fill_ctrl #(.BLANK_ONLY(0)) u0 (
      .i_clk(clk), .i_rst(rst),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(rdy0),
      .i_cmd_x(cmd_x), .i_cmd_y(cmd_y),
      .i_cmd_w(cmd_w), .i_cmd_h(cmd_h),
      .i_cmd_color(cmd_c), .i_blank_n(blank_n),
      .i_abort(abort), .o_wr_en(wr0),
      .o_wr_h_addr(ha0), .o_wr_v_addr(va0),
      .o_wr_data(d0), .o_busy(busy0),
      .o_done(done0), .o_err(err0)
   );

   task automatic check(input bit ok, input string name,
                        input longint act, input longint exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   task automatic mon_wr(input int id, input int h, input int v, input int d);
      wr_t e;
      longint act;
      act = {12'(h), 12'(v), 24'(d)};
      if (id == 1) begin
         check(!blank_n, "u1_wr_while_visible", 1, 0);
         if (q1.size() == 0) begin
            check(0, "u1_unexpected_wr", act, 0);
            return;
         end
         e = q1.pop_front();
      end else begin
         if (q0.size() == 0) begin
            check(0, "u0_unexpected_wr", act, 0);
            return;
         end
         e = q0.pop_front();
      end
      check(e.h == h && e.v == v && e.d == d,
            (id == 1) ? "u1_wr" : "u0_wr",
            act, {12'(e.h), 12'(e.v), 24'(e.d)});
   endtask

   task automatic mon_ev(input int id, input byte kind, input int last);
      byte e;
      e = 0;
      if (id == 1 && ev1.size() != 0) e = ev1.pop_front();
      if (id == 0 && ev0.size() != 0) e = ev0.pop_front();
      check(e == kind, (id == 1) ? "u1_event" : "u0_event", kind, e);
      if (kind == "D") begin
         check(((id == 1) ? q1.size() : q0.size()) == 0,
               "done_with_pending_wr", 1, 0);
         check(cyc == last + 1, "done_latency", cyc - last, 1);
      end
   endtask

   always @(negedge clk) begin
      if (wr1) begin
         n_wr1++;
         last1 = cyc;
         mon_wr(1, int'(ha1), int'(va1), int'(d1));
      end
      if (wr0) begin
         last0 = cyc;
         mon_wr(0, int'(ha0), int'(va0), int'(d0));
      end
      if (done1) mon_ev(1, "D", last1);
      if (err1)  mon_ev(1, "E", last1);
      if (done0) mon_ev(0, "D", last0);
      if (err0)  mon_ev(0, "E", last0);
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (blank_rand) blank_n = 1'($urandom_range(0, 1));
      end
   end

   // Reference: clip to the screen, then enumerate pixels row by row.
   task automatic model(input int x, input int y, input int w, input int h,
                        input int c, input int lim,
                        input bit to0, input bit to1);
      int xe, ye, n;
      wr_t p;
      if (w == 0 || h == 0 || x >= 640 || y >= 480) begin
         ev0.push_back("E");
         ev1.push_back("E");
         return;
      end
      xe = (x + w - 1 > 639) ? 639 : x + w - 1;
      ye = (y + h - 1 > 479) ? 479 : y + h - 1;
      n  = 0;
      for (int v = y; v <= ye; v++) begin
         for (int hh = x; hh <= xe; hh++) begin
            if (lim < 0 || n < lim) begin
               p.h = hh;
               p.v = v;
               p.d = c;
               if (to0) q0.push_back(p);
               if (to1) q1.push_back(p);
            end
            n++;
         end
      end
      if (lim < 0) begin
         if (to0) ev0.push_back("D");
         if (to1) ev1.push_back("D");
      end
   endtask

   task automatic send(input int x, input int y, input int w, input int h,
                       input int c, input int lim,
                       input bit to0, input bit to1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_x = 10'(x);
      cmd_y = 9'(y);
      cmd_w = 10'(w);
      cmd_h = 9'(h);
      cmd_c = 24'(c);
      check(rdy1 && rdy0, "ready_before_cmd", {rdy1, rdy0}, 3);
      @(posedge clk);
      model(x, y, w, h, c, lim, to0, to1);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit ok;
      ok = 0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         if (q0.size() == 0 && q1.size() == 0 &&
             ev0.size() == 0 && ev1.size() == 0) begin
            ok = 1;
            break;
         end
      end
      check(ok, name, q1.size() + ev1.size(), 0);
   endtask

   task automatic chk_reset(input string name);
      check({rdy1, wr1, busy1, done1, err1} == 5'b10000,
            name, {rdy1, wr1, busy1, done1, err1}, 5'b10000);
      check({ha1, va1, d1} == '0, {name, "_regs"}, {ha1, va1, d1}, 0);
      check({rdy0, wr0, busy0, done0, err0} == 5'b10000,
            {name, "_u0"}, {rdy0, wr0, busy0, done0, err0}, 5'b10000);
   endtask

   initial begin
      int base, x, y, w, h;
      bit ok;
      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_x = '0;
      cmd_y = '0;
      cmd_w = '0;
      cmd_h = '0;
      cmd_c = '0;
      blank_n = 1'b0;
      abort = 1'b0;
      #12;
      chk_reset("reset_state");
      @(posedge clk);
      #1;
      rst = 1'b0;

      send(10, 20, 3, 2, 'hFF0000, -1, 1, 1);
      wait_idle("basic_fill");
      send(638, 478, 5, 5, 'h00FF00, -1, 1, 1);
      wait_idle("clip_fill");

      send(5, 5, 0, 3, 'h123456, -1, 1, 1);
      @(negedge clk);
      check(err1 && !rdy1 && !busy1, "err_cycle", {err1, rdy1, busy1}, 3'b100);
      @(negedge clk);
      check(rdy1 && !err1, "err_ready_back", {rdy1, err1}, 2'b10);
      wait_idle("err_w0");
      send(640, 5, 2, 2, 'h123456, -1, 1, 1);
      @(negedge clk);
      @(negedge clk);
      check(rdy1 && !err1, "err_x640_ready", {rdy1, err1}, 2'b10);
      wait_idle("err_x640");

      // visible region: ungated copy fills, gated copy must stall
      blank_n = 1'b1;
      send(10, 20, 3, 2, 'hFF0000, -1, 1, 0);
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         if (ev0.size() == 0) begin
            ok = 1;
            break;
         end
      end
      check(ok, "ungated_fill", ev0.size(), 0);
      #1;
      check(busy1 && ha1 == 10'd10 && va1 == 9'd20, "stalled_at_start",
            {busy1, ha1, va1}, {1'b1, 10'd10, 9'd20});
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check(rdy1 && !busy1, "abort_stalled", {rdy1, busy1}, 2'b10);
      blank_n = 1'b0;

      base = n_wr1;
      send(100, 100, 4, 4, 'hABCDEF, 3, 1, 1);
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         if (n_wr1 >= base + 3) begin
            ok = 1;
            break;
         end
      end
      check(ok, "abort_wait", n_wr1 - base, 3);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check(rdy1 && rdy0 && !busy1, "abort_idle", {rdy1, rdy0, busy1}, 3'b110);
      repeat (4) @(posedge clk);
      check(n_wr1 == base + 3, "abort_count", n_wr1 - base, 3);
      wait_idle("abort_fill");

      base = n_wr1;
      send(200, 100, 4, 4, 'h0000FF, -1, 1, 1);
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         if (n_wr1 >= base + 5) begin
            ok = 1;
            break;
         end
      end
      check(ok, "rst_wait", n_wr1 - base, 5);
      #3;
      rst = 1'b1;
      #1;
      chk_reset("midfill_reset");
      q0.delete();
      q1.delete();
      ev0.delete();
      ev1.delete();
      base = n_wr1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (6) @(posedge clk);
      check(n_wr1 == base && !busy1, "no_wr_after_rst",
            {n_wr1 - base, busy1}, 0);
      send(300, 200, 2, 2, 'h777777, -1, 1, 1);
      wait_idle("after_reset_fill");

      blank_rand = 1;
      for (int k = 0; k < 40; k++) begin
         x = ($urandom_range(0, 9) == 0) ? $urandom_range(630, 700)
                                         : $urandom_range(0, 639);
         y = ($urandom_range(0, 9) == 0) ? $urandom_range(470, 511)
                                         : $urandom_range(0, 479);
         w = $urandom_range(0, 7);
         h = $urandom_range(0, 5);
         send(x, y, w, h, int'($urandom & 32'hFFFFFF), -1, 1, 1);
         wait_idle("rand_fill");
      end
      blank_rand = 0;

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
